lab3_dg_keyscan: RTL and testbench

LAB3_DG_KEYSCAN -- requirements
Module: lab3_dg_keyscan

---
 rtl/lab3_dg_keyscan.sv | 109 ++++++++++
 tb/tb_lab3_dg_keyscan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lab3_dg_keyscan.sv
// lab3_dg_keyscan: 4x4 keypad column scanner with synchronized rows, press/release debounce and single-key lockout.
// Emits a one-cycle key_valid with keypress = {row_n, col_n} when a press is accepted.
module lab3_dg_keyscan #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] keypress,
  output logic       key_valid,
  output logic       key_held
);
  typedef enum logic [1:0] {ST_SCAN, ST_DEB, ST_HELD, ST_REL} state_t;
  localparam logic [7:0] SLOT_MAX = 8'(SCAN_DIV - 1);
  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE - 1);
  state_t state_q, state_d;
  logic [3:0] rows_m_q, rows_s_q;
  logic [3:0] cols_q, cols_d, cols_rot;
  logic [7:0] slot_q, slot_d, cnt_q, cnt_d;
  logic [7:0] cand_q, cand_d, keypress_q, keypress_d;
  logic key_valid_d, key_valid_q, key_held_d, key_held_q;
  logic one_low, all_high, slot_wrap;
  assign cols_rot = {cols_q[2:0], cols_q[3]};
  assign one_low = $countones(~rows_s_q) == 1;
  assign all_high = &rows_s_q;
  assign slot_wrap = slot_q == SLOT_MAX;
  always_comb begin
    state_d = state_q;
    cols_d = cols_q;
    slot_d = slot_q;
    cnt_d = cnt_q;
    cand_d = cand_q;
    keypress_d = keypress_q;
    key_valid_d = 1'b0;
    key_held_d = key_held_q;
    case (state_q)
      ST_SCAN: begin
        slot_d = slot_wrap ? 8'd0 : slot_q + 8'd1;
        cols_d = slot_wrap ? cols_rot : cols_q;
        // rows_s lags the column drive by two flops, so only trust it from slot 2 on
        if (slot_q >= 8'd2 && one_low) begin
          state_d = ST_DEB;
          cand_d = {rows_s_q, cols_q};
          cnt_d = 8'd0;
          slot_d = slot_q;
          cols_d = cols_q;
        end
      end
      ST_DEB: begin
        if (rows_s_q != cand_q[7:4]) begin
          state_d = ST_SCAN;
          slot_d = 8'd0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = ST_HELD;
          keypress_d = cand_q;
          key_valid_d = 1'b1;
          key_held_d = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
      end
      ST_HELD: begin
        if (all_high) begin
          state_d = ST_REL;
          cnt_d = 8'd0;
        end
      end
      ST_REL: begin
        if (!all_high) state_d = ST_HELD;
        else if (cnt_q == DEB_MAX) begin
          state_d = ST_SCAN;
          key_held_d = 1'b0;
          cols_d = cols_rot;
          slot_d = 8'd0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: state_d = ST_SCAN;
    endcase
  end
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      rows_m_q <= 4'hF;
      rows_s_q <= 4'hF;
      state_q <= ST_SCAN;
      cols_q <= 4'b1110;
      slot_q <= 8'd0;
      cnt_q <= 8'd0;
      cand_q <= 8'hFF;
      keypress_q <= 8'hFF;
      key_valid_q <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      rows_m_q <= rows;
      rows_s_q <= rows_m_q;
      state_q <= state_d;
      cols_q <= cols_d;
      slot_q <= slot_d;
      cnt_q <= cnt_d;
      cand_q <= cand_d;
      keypress_q <= keypress_d;
      key_valid_q <= key_valid_d;
      key_held_q <= key_held_d;
    end
  end
  assign cols = cols_q;
  assign keypress = keypress_q;
  assign key_valid = key_valid_q;
  assign key_held = key_held_q;
endmodule

// File: tb/tb_lab3_dg_keyscan.sv
// tb_lab3_dg_keyscan: keypad model drives rows from cols; accepted keys are checked against a scoreboard queue.
module tb_lab3_dg_keyscan;
  logic int_osc, reset;
  logic [3:0] rows, cols;
  logic [7:0] keypress;
  logic key_valid, key_held;
  logic key_on, ovr, kv_prev;
  logic [3:0] key_row, rows_ovr;
  int key_col;
  int n_chk, n_fail, pulses, exp_pulses;
  logic [7:0] sb[$];

  lab3_dg_keyscan dut (
    .int_osc(int_osc), .reset(reset), .rows(rows), .cols(cols),
    .keypress(keypress), .key_valid(key_valid), .key_held(key_held)
  );

  assign rows = ovr ? rows_ovr : (key_on && !cols[key_col]) ? key_row : 4'hF;

  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(negedge int_osc);
    #1;
  endtask

  task automatic wait_col(input int c);
    logic [3:0] t, prev;
    logic found;
    t = ~(4'b1 << c);
    prev = cols;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      found = (cols == t) && (prev != t);
      prev = cols;
    end
    chk("col_sync", found, 1);
  endtask

  // press lands right after column c starts: pulse expected exactly 11 edges later
  task automatic press_key(input logic [3:0] row, input int c, input logic [7:0] kp);
    int p0;
    logic [3:0] t;
    t = ~(4'b1 << c);
    wait_col(c);
    p0 = pulses;
    key_row = row;
    key_col = c;
    key_on = 1'b1;
    sb.push_back(kp);
    exp_pulses++;
    repeat (10) step();
    chk("press_early", key_valid, 0);
    step();
    chk("press_valid", key_valid, 1);
    chk("press_kp", keypress, kp);
    chk("press_held", key_held, 1);
    repeat (2) step();
    chk("press_count", pulses, p0 + 1);
    chk("press_cols", cols, t);
  endtask

  task automatic release_key;
    int p0;
    p0 = pulses;
    key_on = 1'b0;
    repeat (25) step();
    chk("rel_held", key_held, 0);
    chk("rel_nopulse", pulses, p0);
  endtask

  always @(negedge int_osc) begin
    chk("cols_onehot", $countones(~cols), 1);
    chk("kv_consec", key_valid & kv_prev, 0);
    kv_prev = key_valid;
    if (key_valid) begin
      pulses++;
      chk("sb_avail", sb.size() > 0, 1);
      if (sb.size() > 0) chk("sb_keypress", keypress, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    int p0;
    n_chk = 0; n_fail = 0; pulses = 0; exp_pulses = 0; kv_prev = 1'b0;
    key_on = 1'b0; ovr = 1'b0; rows_ovr = 4'hF; key_row = 4'hF; key_col = 0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_cols", cols, 4'b1110);
    chk("rst_kp", keypress, 8'hFF);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    reset = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      step();
      ec = ~(4'b1 << ((i / 4) % 4));
      chk("idle_cols", cols, ec);
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_kp", keypress, 8'hFF);

    press_key(4'b1101, 0, 8'b1101_1110);
    repeat (20) step();
    chk("held_cols", cols, 4'b1110);
    chk("held_level", key_held, 1);

    p0 = pulses;
    key_on = 1'b0;
    repeat (4) step();
    key_on = 1'b1;
    repeat (4) step();
    chk("glitch_held", key_held, 1);
    key_on = 1'b0;
    repeat (9) step();
    chk("glitch_still_held", key_held, 1);
    chk("glitch_cols", cols, 4'b1110);
    repeat (3) step();
    chk("glitch_released", key_held, 0);
    chk("glitch_next_col", cols, 4'b1101);
    chk("glitch_nopulse", pulses, p0);

    press_key(4'b1101, 0, 8'b1101_1110);
    release_key();

    wait_col(0);
    p0 = pulses;
    key_row = 4'b1101;
    key_col = 0;
    for (int j = 0; j < 7; j++) begin
      key_on = (j % 2 == 0);
      if (j == 6) begin
        sb.push_back(8'b1101_1110);
        exp_pulses++;
      end
      repeat (3) step();
    end
    repeat (7) step();
    chk("bounce_early", key_valid, 0);
    chk("bounce_nopulse", pulses, p0);
    step();
    chk("bounce_valid", key_valid, 1);
    chk("bounce_kp", keypress, 8'b1101_1110);
    release_key();

    wait_col(0);
    p0 = pulses;
    ovr = 1'b1;
    rows_ovr = 4'b1001;
    repeat (40) step();
    chk("dual_cols", cols, 4'b1011);
    chk("dual_nopulse", pulses, p0);
    chk("dual_held", key_held, 0);
    ovr = 1'b0;
    repeat (4) step();

    press_key(4'b1101, 0, 8'b1101_1110);
    p0 = pulses;
    reset = 1'b1;
    key_on = 1'b0;
    #1;
    chk("hrst_cols", cols, 4'b1110);
    chk("hrst_kp", keypress, 8'hFF);
    chk("hrst_valid", key_valid, 0);
    chk("hrst_held", key_held, 0);
    repeat (2) step();
    reset = 1'b0;
    chk("hrst_restart", cols, 4'b1110);
    repeat (3) step();
    chk("hrst_nopulse", pulses, p0);
    press_key(4'b1011, 3, 8'b1011_0111);
    release_key();
    chk("final_kp", keypress, 8'b1011_0111);

    chk("sb_empty", sb.size(), 0);
    chk("pulse_total", pulses, exp_pulses);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
